// File: rtl/ahb_xfer_sequencer.sv
// ahb_xfer_sequencer
//   Command front end for the AHB manager. Takes one transfer descriptor at a
//   time and expands it into the manager's per-beat user interface, honouring
//   the manager's registered stall.
//
// Ports
//   i_hclk, i_hreset_n          clock, async active-low reset
//   i_cmd_*  / o_cmd_ready      descriptor handshake and fields
//   i_wdata_valid/o_wdata_ready write-data handshake, i_wdata payload
//   i_mgr_stall                 manager stall
//   o_mgr_*                     manager user-side inputs
//   o_done / o_cmd_err          completion / rejection pulses
//
// Build option
//   FREEAHB_SEQ_WRAP_EN : when defined, i_cmd_mask freezes the masked address
//   bits at their start value and is driven on o_mgr_mask. When undefined the
//   mask is ignored, o_mgr_mask is 0 and addresses increment linearly.
//
// state | meaning
// IDLE  | waiting for a descriptor, manager sees idle
// FIRST | presenting the first beat (first_xfer=1)
// BURST | presenting subsequent beats
// DONE  | one-cycle completion pulse, then IDLE

module ahb_xfer_sequencer #(
  parameter int DATA_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [15:0]         i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_write,
  input  logic [31:0]         i_cmd_mask,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  input  logic                i_mgr_stall,
  output logic                o_mgr_idle,
  output logic                o_mgr_rd,
  output logic                o_mgr_wr,
  output logic                o_mgr_first_xfer,
  output logic [31:0]         o_mgr_addr,
  output logic [31:0]         o_mgr_mask,
  output logic [2:0]          o_mgr_size,
  output logic [15:0]         o_mgr_min_len,
  output logic [DATA_WDT-1:0] o_mgr_wr_data,
  output logic                o_done,
  output logic                o_cmd_err
);

  localparam int MAX_SIZE = $clog2(DATA_WDT / 8);

  typedef enum logic [1:0] {IDLE, FIRST, BURST, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [15:0] remain_q;
  logic [2:0]  size_q;
  logic        write_q;
  logic        cmd_ready_q;
  logic        idle_q;
  logic        first_q;
  logic        rd_q;
  logic        wr_en_q;
  logic        wr_hold_q;
  logic        done_q;
  logic        err_q;

  logic        active;
  logic        wr_now;
  logic        beat_acc;
  logic        cmd_bad;
  logic [31:0] addr_inc;
  logic [31:0] addr_next;

`ifdef FREEAHB_SEQ_WRAP_EN
  logic [31:0] mask_q;
  logic [31:0] start_q;

  assign addr_next  = (addr_inc & ~mask_q) | (start_q & mask_q);
  assign o_mgr_mask = mask_q;
`else
  logic unused_mask;

  assign unused_mask = ^i_cmd_mask;
  assign addr_next   = addr_inc;
  assign o_mgr_mask  = '0;
`endif

  assign active   = (state == FIRST) || (state == BURST);
  assign addr_inc = addr_q + (32'd1 << size_q);
  assign cmd_bad  = (i_cmd_len == 16'd0) || (int'(i_cmd_size) > MAX_SIZE);

  // Write strobe follows data availability, but is frozen at the value the
  // manager last saw while it is stalling so the presented beat never changes.
  assign wr_now   = wr_en_q & (i_mgr_stall ? wr_hold_q : i_wdata_valid);
  assign beat_acc = active & (rd_q | wr_now) & ~i_mgr_stall;

  assign o_cmd_ready      = cmd_ready_q;
  assign o_mgr_idle       = idle_q;
  assign o_mgr_first_xfer = first_q;
  assign o_mgr_rd         = rd_q;
  assign o_mgr_wr         = wr_now;
  assign o_mgr_addr       = addr_q;
  assign o_mgr_size       = size_q;
  assign o_mgr_min_len    = remain_q;
  assign o_mgr_wr_data    = i_wdata;
  assign o_wdata_ready    = write_q & active & ~i_mgr_stall;
  assign o_done           = done_q;
  assign o_cmd_err        = err_q;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      idle_q      <= 1'b1;
      first_q     <= 1'b1;
      rd_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_hold_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef FREEAHB_SEQ_WRAP_EN
      mask_q      <= '0;
      start_q     <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_hold_q <= wr_now;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            addr_q   <= i_cmd_addr;
            remain_q <= i_cmd_len;
            size_q   <= i_cmd_size;
            write_q  <= i_cmd_write;
`ifdef FREEAHB_SEQ_WRAP_EN
            mask_q   <= i_cmd_mask;
            start_q  <= i_cmd_addr;
`endif
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              state       <= FIRST;
              cmd_ready_q <= 1'b0;
              idle_q      <= 1'b0;
              rd_q        <= ~i_cmd_write;
              wr_en_q     <= i_cmd_write;
            end
          end
        end
        FIRST, BURST: begin
          if (beat_acc) begin
            addr_q   <= addr_next;
            remain_q <= remain_q - 16'd1;
            first_q  <= 1'b0;
            if (remain_q == 16'd1) begin
              // Last beat: DONE looks like IDLE to the manager.
              state   <= DONE;
              done_q  <= 1'b1;
              idle_q  <= 1'b1;
              first_q <= 1'b1;
              rd_q    <= 1'b0;
              wr_en_q <= 1'b0;
            end else begin
              state <= BURST;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
